// File: rtl/pht_maint_ctrl.sv
// pht_maint_ctrl
// Maintenance controller for the global-history PHT (2^GHR_LENGTH entries of
// 2-bit saturating counters in an external RAM with one synchronous-read port
// and one write port). It owns the only write port. It clears the table after
// reset and on flush. It turns MEM-stage training requests into a two-stage
// read-modify-write with forwarding.
//
// Ports:
//   clk, rst        single clock; asynchronous active-low reset
//   flush_req       one-cycle request to re-clear the whole table
//   upd_valid/index/taken   training request from MEM
//   upd_ready       request accepted this cycle
//   upd_dropped     upd_valid & ~upd_ready
//   pht_raddr       RAM read address (data returns on pht_rdata next cycle)
//   pht_rdata       RAM read data
//   pht_we/waddr/wdata      RAM write port
//   pht_ready       table contents valid for prediction
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_SWEEP | writing INIT_STATE to every index, one per cycle, counter 0..max
// ST_RUN   | table valid; training requests accepted and written one cycle later

module pht_maint_ctrl #(
   parameter int         GHR_LENGTH = 8,
   parameter logic [1:0] INIT_STATE = 2'b11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_req,
   input  logic                  upd_valid,
   input  logic [GHR_LENGTH-1:0] upd_index,
   input  logic                  upd_taken,
   output logic                  upd_ready,
   output logic                  upd_dropped,
   output logic [GHR_LENGTH-1:0] pht_raddr,
   input  logic [1:0]            pht_rdata,
   output logic                  pht_we,
   output logic [GHR_LENGTH-1:0] pht_waddr,
   output logic [1:0]            pht_wdata,
   output logic                  pht_ready
);

   localparam logic [GHR_LENGTH-1:0] LAST_IDX = '1;

   typedef enum logic {ST_SWEEP, ST_RUN} state_t;

   state_t                  state;
   logic [GHR_LENGTH-1:0]   sweep_cnt;
   logic                    s1_valid;
   logic [GHR_LENGTH-1:0]   s1_index;
   logic                    s1_taken;
   logic                    lw_valid;
   logic [GHR_LENGTH-1:0]   lw_index;
   logic [1:0]              lw_data;

   logic                    in_run;
   logic                    sweep_wr;
   logic                    train_wr;
   logic                    accept;
   logic [1:0]              old_val;
   logic [1:0]              next_val;

   // Encoding: 00 SNT, 01 WNT, 11 WT, 10 ST (Gray-ordered).
   function automatic logic [1:0] sat_next(input logic [1:0] old, input logic taken);
      logic [1:0] res;
      res = old;
      case (old)
         2'b00:   res = taken ? 2'b01 : 2'b00;
         2'b01:   res = taken ? 2'b11 : 2'b00;
         2'b11:   res = taken ? 2'b10 : 2'b01;
         2'b10:   res = taken ? 2'b10 : 2'b11;
         default: res = old;
      endcase
      return res;
   endfunction

   assign in_run = (state == ST_RUN);

   // A flush seen in RUN starts the sweep in the same cycle, writing index 0
   // in place of any pending training write. sweep_cnt is held at 0 in RUN.
   // The rst term keeps the write port quiet while reset is held.
   assign sweep_wr = rst & ((state == ST_SWEEP) | (in_run & flush_req));
   assign train_wr = in_run & ~flush_req & s1_valid;

   assign upd_ready   = in_run & ~flush_req;
   assign upd_dropped = upd_valid & ~upd_ready;
   assign accept      = upd_valid & upd_ready;

   // The RAM read issued in S0 cannot see a write committed on the same edge,
   // so the most recent training write is forwarded for one cycle.
   assign old_val  = (lw_valid && (lw_index == s1_index)) ? lw_data : pht_rdata;
   assign next_val = sat_next(old_val, s1_taken);

   assign pht_raddr = in_run ? upd_index : '0;
   assign pht_we    = sweep_wr | train_wr;
   assign pht_waddr = sweep_wr ? sweep_cnt  : (train_wr ? s1_index : '0);
   assign pht_wdata = sweep_wr ? INIT_STATE : (train_wr ? next_val : 2'b00);
   assign pht_ready = in_run;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_SWEEP;
         sweep_cnt <= '0;
         s1_valid  <= 1'b0;
         s1_index  <= '0;
         s1_taken  <= 1'b0;
         lw_valid  <= 1'b0;
         lw_index  <= '0;
         lw_data   <= 2'b00;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_index <= upd_index;
            s1_taken <= upd_taken;
         end

         lw_valid <= train_wr;
         if (train_wr) begin
            lw_index <= s1_index;
            lw_data  <= next_val;
         end

         case (state)
            ST_SWEEP: begin
               if (flush_req) begin
                  sweep_cnt <= '0;
               end else if (sweep_cnt == LAST_IDX) begin
                  sweep_cnt <= '0;
                  state     <= ST_RUN;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (flush_req) begin
                  sweep_cnt <= '0;
                  state     <= ST_SWEEP;
               end
            end
            default: begin
               state     <= ST_SWEEP;
               sweep_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pht_maint_ctrl.sv
// Directed bench for pht_maint_ctrl with a read-before-write RAM model.
module tb_pht_maint_ctrl;

   logic       clk;
   logic       rst;
   logic       flush_req;
   logic       upd_valid;
   logic [7:0] upd_index;
   logic       upd_taken;
   logic       upd_ready;
   logic       upd_dropped;
   logic [7:0] pht_raddr;
   logic [1:0] pht_rdata;
   logic       pht_we;
   logic [7:0] pht_waddr;
   logic [1:0] pht_wdata;
   logic       pht_ready;

   logic [1:0] ram [0:255];
   int         bad_wr;
   int         n_tests;
   int         n_fail;
   int         bad_snap;

   pht_maint_ctrl #(.GHR_LENGTH(8), .INIT_STATE(2'b11)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_req   (flush_req),
      .upd_valid   (upd_valid),
      .upd_index   (upd_index),
      .upd_taken   (upd_taken),
      .upd_ready   (upd_ready),
      .upd_dropped (upd_dropped),
      .pht_raddr   (pht_raddr),
      .pht_rdata   (pht_rdata),
      .pht_we      (pht_we),
      .pht_waddr   (pht_waddr),
      .pht_wdata   (pht_wdata),
      .pht_ready   (pht_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM; a read of the index being written returns old data.
   always @(posedge clk) begin
      if (pht_we) ram[pht_waddr] <= pht_wdata;
      pht_rdata <= ram[pht_raddr];
   end

   // Any non-init write to the indices that must only ever see sweep writes.
   always @(posedge clk) begin
      if (pht_we && (pht_wdata != 2'b11) && (pht_waddr == 8'h80 || pht_waddr == 8'd10))
         bad_wr <= bad_wr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle per iteration: drive at negedge, check 1 ns later.
   // A flush is injected once at sweep index flush_at; the loop returns after
   // checking index stop_at or after the full 256-entry sweep.
   task automatic run_sweep(input int flush_at, input int stop_at);
      int  exp_i;
      int  guard;
      bit  flushed;
      bit  do_flush;
      exp_i   = 0;
      guard   = 0;
      flushed = 0;
      while (guard < 700) begin
         @(negedge clk);
         do_flush  = !flushed && (exp_i == flush_at);
         flush_req = do_flush;
         upd_valid = (exp_i == 10);
         upd_index = 8'd10;
         upd_taken = 1'b0;
         #1;
         chk("sweep_we",    32'(pht_we),    32'd1);
         chk("sweep_waddr", 32'(pht_waddr), 32'(exp_i));
         chk("sweep_wdata", 32'(pht_wdata), 32'd3);
         chk("sweep_ready", 32'(pht_ready), 32'd0);
         chk("sweep_updrdy", 32'(upd_ready), 32'd0);
         if (exp_i == 10) chk("sweep_dropped", 32'(upd_dropped), 32'd1);
         if (exp_i == stop_at) break;
         if (do_flush) begin
            exp_i   = 0;
            flushed = 1;
         end else begin
            exp_i++;
         end
         if (exp_i == 256) break;
         guard++;
      end
      chk("sweep_bounded", 32'(guard < 700), 32'd1);
      flush_req = 1'b0;
      upd_valid = 1'b0;
   endtask

   task automatic check_idle_run(input string tag);
      @(negedge clk);
      flush_req = 1'b0;
      upd_valid = 1'b0;
      #1;
      chk({tag, "_ready"}, 32'(pht_ready), 32'd1);
      chk({tag, "_we"},    32'(pht_we),    32'd0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b0;
      flush_req = 1'b0;
      upd_valid = 1'b0;
      upd_index = 8'd0;
      upd_taken = 1'b0;

      // Reset values
      #3;
      chk("rst_we",     32'(pht_we),    32'd0);
      chk("rst_waddr",  32'(pht_waddr), 32'd0);
      chk("rst_wdata",  32'(pht_wdata), 32'd0);
      chk("rst_ready",  32'(pht_ready), 32'd0);
      chk("rst_updrdy", 32'(upd_ready), 32'd0);

      // Initial sweep, with a dropped request at index 10
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      run_sweep(-1, 256);
      check_idle_run("init_done");
      check_idle_run("init_quiet");
      chk("ram10_init", 32'(ram[10]), 32'd3);
      chk("no_bad_wr_init", 32'(bad_wr), 32'd0);

      // Single taken update to 0x3C: 11 -> 10
      @(negedge clk);
      upd_valid = 1'b1; upd_index = 8'h3C; upd_taken = 1'b1;
      #1;
      chk("t1_raddr",  32'(pht_raddr), 32'h3C);
      chk("t1_updrdy", 32'(upd_ready), 32'd1);
      chk("t1_drop",   32'(upd_dropped), 32'd0);
      chk("t1_we_s0",  32'(pht_we),    32'd0);
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      chk("t1_we",    32'(pht_we),    32'd1);
      chk("t1_waddr", 32'(pht_waddr), 32'h3C);
      chk("t1_wdata", 32'(pht_wdata), 32'b10);

      // Three back-to-back not-taken to 0x05: 11 -> 01 -> 00 -> 00
      @(negedge clk);
      upd_valid = 1'b1; upd_index = 8'h05; upd_taken = 1'b0;
      #1;
      chk("t2_we_c1", 32'(pht_we), 32'd0);
      @(negedge clk);
      #1;
      chk("t2_waddr_c2", 32'(pht_waddr), 32'h05);
      chk("t2_wdata_c2", 32'(pht_wdata), 32'b01);
      @(negedge clk);
      #1;
      chk("t2_we_c3",    32'(pht_we),    32'd1);
      chk("t2_wdata_c3", 32'(pht_wdata), 32'b00);
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      chk("t2_wdata_c4", 32'(pht_wdata), 32'b00);
      @(negedge clk);
      #1;
      chk("t2_we_c5", 32'(pht_we), 32'd0);
      chk("t2_ram05", 32'(ram[5]), 32'd0);

      // 0x09: not-taken then taken back-to-back: 11 -> 01 -> 11 (forwarded)
      @(negedge clk);
      upd_valid = 1'b1; upd_index = 8'h09; upd_taken = 1'b0;
      @(negedge clk);
      upd_taken = 1'b1;
      #1;
      chk("t3_wdata_a", 32'(pht_wdata), 32'b01);
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      chk("t3_waddr_b", 32'(pht_waddr), 32'h09);
      chk("t3_wdata_b", 32'(pht_wdata), 32'b11);

      // Flush in RUN while S1 holds 0x80 and a new request arrives
      bad_snap = bad_wr;
      @(negedge clk);
      upd_valid = 1'b1; upd_index = 8'h80; upd_taken = 1'b1;
      #1;
      chk("t4_updrdy", 32'(upd_ready), 32'd1);
      @(negedge clk);
      flush_req = 1'b1; upd_valid = 1'b1; upd_index = 8'h22;
      #1;
      chk("t4_updrdy_fl", 32'(upd_ready),   32'd0);
      chk("t4_dropped",   32'(upd_dropped), 32'd1);
      chk("t4_we",        32'(pht_we),      32'd1);
      chk("t4_waddr",     32'(pht_waddr),   32'd0);
      chk("t4_wdata",     32'(pht_wdata),   32'd3);
      run_sweep(-1, 256);
      check_idle_run("t4_done");
      chk("t4_no_0x80_train", 32'(bad_wr - bad_snap), 32'd0);
      chk("t4_ram80", 32'(ram[8'h80]), 32'd3);
      chk("t4_ram22", 32'(ram[8'h22]), 32'd3);

      // Flush during sweep restarts the counter at 0
      @(negedge clk);
      flush_req = 1'b1;
      #1;
      chk("t5_waddr", 32'(pht_waddr), 32'd0);
      run_sweep(30, 256);
      check_idle_run("t5_done");

      // Reset pulse at sweep index 100
      @(negedge clk);
      flush_req = 1'b1;
      run_sweep(-1, 100);
      #1 rst = 1'b0;
      #1;
      chk("t6_we",     32'(pht_we),    32'd0);
      chk("t6_waddr",  32'(pht_waddr), 32'd0);
      chk("t6_wdata",  32'(pht_wdata), 32'd0);
      chk("t6_ready",  32'(pht_ready), 32'd0);
      @(negedge clk);
      #1;
      chk("t6_we_held", 32'(pht_we), 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      run_sweep(-1, 256);
      check_idle_run("t6_done");
      chk("no_bad_wr_end", 32'(bad_wr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
